// File: rtl/pipe_stage_latch.sv
// pipe_stage_latch: elastic 2-entry skid pipeline register with flush and NOP bubbles; PIPE_STAGE_PERF_EN adds stall/bubble counters
module pipe_stage_latch #(
  parameter int LANES  = 6,
  parameter int WIDTH  = 16,
  parameter int CTRL_W = 10
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [LANES-1:0][WIDTH-1:0]       in_data,
  input  logic [CTRL_W-1:0]                 in_ctrl,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [LANES-1:0][WIDTH-1:0]       out_data,
  output logic [CTRL_W-1:0]                 out_ctrl,
  input  logic                              flush,
  output logic [1:0]                        occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [15:0]                       stall_cnt,
  output logic [15:0]                       bubble_cnt
`endif
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  state_t state_q, state_d;
  logic [LANES-1:0][WIDTH-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic acc, ret;
  assign in_ready  = state_q != FULL;
  assign out_valid = state_q != EMPTY;
  assign out_data  = main_data_q;
  assign out_ctrl  = out_valid ? main_ctrl_q : '0;
  assign occupancy = state_q;
  always_comb begin
    acc         = in_valid & in_ready;
    ret         = out_valid & out_ready;
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush) begin
      state_d = EMPTY;
    end else if (state_q == FULL) begin
      if (ret) begin
        state_d     = ONE;
        main_data_d = skid_data_q;
        main_ctrl_d = skid_ctrl_q;
      end
    end else if (acc && (state_q == EMPTY || ret)) begin
      state_d     = ONE;
      main_data_d = in_data;
      main_ctrl_d = in_ctrl;
    end else if (acc) begin
      state_d     = FULL;
      skid_data_d = in_data;
      skid_ctrl_d = in_ctrl;
    end else if (ret) begin
      state_d = EMPTY;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
`ifdef PIPE_STAGE_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;
  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
  always_comb begin
    stall_cnt_d  = (out_valid && !out_ready && !(&stall_cnt_q)) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    bubble_cnt_d = (!out_valid && !(&bubble_cnt_q)) ? bubble_cnt_q + 16'd1 : bubble_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
`endif
endmodule

// File: tb/tb_pipe_stage_latch.sv
// tb_pipe_stage_latch: queue-model self-checking bench for pipe_stage_latch
module tb_pipe_stage_latch;
  localparam int LANES = 6, WIDTH = 16, CTRL_W = 10, DW = LANES * WIDTH;
  logic clk = 0, rst_n = 1, in_valid = 0, out_ready = 0, flush = 0;
  logic [LANES-1:0][WIDTH-1:0] in_data = '0, out_data;
  logic [CTRL_W-1:0] in_ctrl = '0, out_ctrl;
  logic in_ready, out_valid;
  logic [1:0] occupancy;
  typedef struct packed {logic [DW-1:0] d; logic [CTRL_W-1:0] c;} ent_t;
  ent_t q[$];
  logic [DW-1:0] exp_data = '0;
  int errors = 0, checks = 0, sz;
  bit acc, ret;
`ifdef PIPE_STAGE_PERF_EN
  logic [15:0] stall_cnt, bubble_cnt;
  int exp_stall = 0, exp_bubble = 0;
`endif
  always #5 clk = ~clk;
  pipe_stage_latch #(.LANES(LANES), .WIDTH(WIDTH), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ctrl(out_ctrl), .flush(flush), .occupancy(occupancy)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );
  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(posedge clk) begin
    if (rst_n) begin
      sz  = q.size();
      ret = sz > 0 && out_ready;
      acc = in_valid && sz < 2;
`ifdef PIPE_STAGE_PERF_EN
      if (sz > 0 && !out_ready && exp_stall < 65535) exp_stall++;
      if (sz == 0 && exp_bubble < 65535) exp_bubble++;
`endif
      if (flush) q.delete();
      else begin
        if (ret) void'(q.pop_front());
        if (acc) q.push_back(ent_t'{in_data, in_ctrl});
      end
      if (q.size() > 0) exp_data = q[0].d;
      #1;
      chk("in_ready", DW'(in_ready), DW'(q.size() < 2));
      chk("out_valid", DW'(out_valid), DW'(q.size() > 0));
      chk("occupancy", DW'(occupancy), DW'(q.size()));
      chk("out_data", out_data, exp_data);
      chk("out_ctrl", DW'(out_ctrl), q.size() > 0 ? DW'(q[0].c) : '0);
`ifdef PIPE_STAGE_PERF_EN
      chk("stall_cnt", DW'(stall_cnt), DW'(exp_stall));
      chk("bubble_cnt", DW'(bubble_cnt), DW'(exp_bubble));
`endif
    end
  end
  task automatic step(input logic v, input logic [WIDTH-1:0] w, input logic [CTRL_W-1:0] c,
                      input logic r, input logic f);
    @(negedge clk);
    in_valid = v; in_data = {LANES{w}}; in_ctrl = c; out_ready = r; flush = f;
    @(posedge clk);
    #2;
  endtask
  task automatic reset_now();
    rst_n = 0;
    #1;
    chk("rst out_valid", DW'(out_valid), '0);
    chk("rst in_ready", DW'(in_ready), DW'(1));
    chk("rst occupancy", DW'(occupancy), '0);
    chk("rst out_ctrl", DW'(out_ctrl), '0);
    chk("rst out_data", out_data, '0);
    q.delete();
    exp_data = '0;
`ifdef PIPE_STAGE_PERF_EN
    exp_stall = 0;
    exp_bubble = 0;
`endif
    @(negedge clk);
    rst_n = 1;
  endtask
  initial begin
    #2;
    reset_now();
    step(1, 16'h1111, 10'h001, 1, 0);
    chk("stream first", DW'(out_data[0]), DW'(16'h1111));
    for (int k = 1; k < 5; k++) begin
      step(1, 16'h1111 + 16'(k), 10'h001, 1, 0);
      chk("stream data", DW'(out_data[0]), DW'(16'h1111 + 16'(k)));
      chk("stream in_ready", DW'(in_ready), DW'(1));
    end
    step(0, 16'h0, 10'h0, 1, 0);
    chk("stream hold", DW'(out_data[0]), DW'(16'h1115));
    step(1, 16'hAAAA, 10'h002, 0, 0);
    step(1, 16'hBBBB, 10'h003, 0, 0);
    chk("skid occupancy", DW'(occupancy), DW'(2));
    chk("skid in_ready", DW'(in_ready), '0);
    chk("skid head", DW'(out_data[0]), DW'(16'hAAAA));
    step(0, 16'h0, 10'h0, 1, 0);
    chk("skid second", DW'(out_data[0]), DW'(16'hBBBB));
    step(0, 16'h0, 10'h0, 1, 0);
    chk("skid drained", DW'(out_valid), '0);
    step(1, 16'h0001, 10'h005, 0, 0);
    step(1, 16'h0002, 10'h006, 0, 0);
    step(1, 16'hCCCC, 10'h007, 1, 1);
    chk("flush occupancy", DW'(occupancy), '0);
    chk("flush out_ctrl", DW'(out_ctrl), '0);
    step(0, 16'h0, 10'h0, 1, 0);
    chk("flush no CCCC", DW'(out_data[0]), DW'(16'h0001));
    step(1, 16'h5555, 10'h3FF, 1, 0);
    chk("bubble ctrl on", DW'(out_ctrl), DW'(10'h3FF));
    step(0, 16'h0, 10'h0, 1, 0);
    chk("bubble ctrl off", DW'(out_ctrl), '0);
    chk("bubble data hold", DW'(out_data[0]), DW'(16'h5555));
    step(1, 16'h0007, 10'h001, 0, 0);
    step(1, 16'h0008, 10'h002, 0, 0);
    chk("pre-reset occupancy", DW'(occupancy), DW'(2));
    in_valid = 0;
    reset_now();
    repeat (400)
      step($urandom_range(0, 9) < 7, 16'($urandom), 10'($urandom), $urandom_range(0, 9) < 6,
           $urandom_range(0, 19) == 0);
`ifdef PIPE_STAGE_PERF_EN
    step(1, 16'h0009, 10'h001, 0, 0);
    repeat (70000) step(0, 16'h0, 10'h0, 0, 0);
    chk("stall saturated", DW'(stall_cnt), DW'(16'hFFFF));
    step(0, 16'h0, 10'h0, 0, 0);
    chk("stall stays", DW'(stall_cnt), DW'(16'hFFFF));
`endif
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
